// File: rtl/lut_neuron_pkg.sv
// Shared types and sizing helpers for the runtime-loadable LUT neuron.
package lut_neuron_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} ld_state_t;

    function automatic int cfg_epb(input int cfg_w, input int out_bits);
        return cfg_w / out_bits;
    endfunction

    function automatic int cfg_beats(input int in_bits, input int out_bits, input int cfg_w);
        return (1 << in_bits) / cfg_epb(cfg_w, out_bits);
    endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Distributed-RAM truth table: beat-wide write port, single asynchronous read port.
module lut_table_ram
    import lut_neuron_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int CFG_W    = 8,
    parameter int BEAT_W   = 5
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [BEAT_W-1:0]   wr_beat,
    input  logic [CFG_W-1:0]    wr_data,
    input  logic [IN_BITS-1:0]  rd_addr,
    output logic [OUT_BITS-1:0] rd_data
);

    localparam int DEPTH = 1 << IN_BITS;
    localparam int EPB   = cfg_epb(CFG_W, OUT_BITS);

    logic [OUT_BITS-1:0] mem [DEPTH];

    // One beat fills EPB consecutive entries, lowest entry in the lowest bits.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < EPB; k++) begin
                mem[IN_BITS'(int'(wr_beat) * EPB + k)] <= wr_data[k*OUT_BITS +: OUT_BITS];
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lut_neuron_table_loader.sv
// Runtime-programmable LUT neuron: streamed table loader plus registered 1-cycle lookup.
module lut_neuron_table_loader
    import lut_neuron_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int CFG_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CFG_W-1:0]    cfg_data,
    output logic                cfg_busy,
    output logic                cfg_done,
    output logic                table_loaded,
    input  logic [IN_BITS-1:0]  M0,
    input  logic                M0_valid,
    output logic [OUT_BITS-1:0] M1,
    output logic                M1_valid
);

    localparam int BEATS  = cfg_beats(IN_BITS, OUT_BITS, CFG_W);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    ld_state_t           state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                cfg_busy_q, cfg_busy_d;
    logic                cfg_done_q, cfg_done_d;
    logic                table_loaded_q, table_loaded_d;
    logic [OUT_BITS-1:0] m1_q, m1_d;
    logic                m1_valid_q, m1_valid_d;
    logic                wr_en;
    logic [OUT_BITS-1:0] rd_data;

    lut_table_ram #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .CFG_W    (CFG_W),
        .BEAT_W   (BEAT_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_beat (beat_q),
        .wr_data (cfg_data),
        .rd_addr (M0),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        table_loaded_d = table_loaded_q;
        wr_en          = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d        = LOAD;
                    beat_d         = '0;
                    table_loaded_d = 1'b0;
                end
            end
            LOAD: begin
                // A restart wins over a beat offered in the same cycle.
                if (cfg_start) begin
                    beat_d = '0;
                end else if (cfg_valid && cfg_ready_q) begin
                    wr_en = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            DONE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    beat_d  = '0;
                end else begin
                    state_d        = IDLE;
                    table_loaded_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        cfg_ready_d = (state_d == LOAD);
        cfg_busy_d  = (state_d == LOAD);
        cfg_done_d  = (state_d == DONE);

        // Lookups are only served from a complete image with no write in flight.
        m1_valid_d = M0_valid && table_loaded_q && !cfg_busy_q;
        m1_d       = m1_valid_d ? rd_data : m1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            beat_q         <= '0;
            cfg_ready_q    <= 1'b0;
            cfg_busy_q     <= 1'b0;
            cfg_done_q     <= 1'b0;
            table_loaded_q <= 1'b0;
            m1_q           <= '0;
            m1_valid_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_q         <= beat_d;
            cfg_ready_q    <= cfg_ready_d;
            cfg_busy_q     <= cfg_busy_d;
            cfg_done_q     <= cfg_done_d;
            table_loaded_q <= table_loaded_d;
            m1_q           <= m1_d;
            m1_valid_q     <= m1_valid_d;
        end
    end

    assign cfg_ready    = cfg_ready_q;
    assign cfg_busy     = cfg_busy_q;
    assign cfg_done     = cfg_done_q;
    assign table_loaded = table_loaded_q;
    assign M1           = m1_q;
    assign M1_valid     = m1_valid_q;

endmodule

// File: tb/tb_lut_neuron_table_loader.sv
// Directed self-checking bench for lut_neuron_table_loader at default parameters.
module tb_lut_neuron_table_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_ready;
    logic       cfg_busy;
    logic       cfg_done;
    logic       table_loaded;
    logic [7:0] M0 = 8'h00;
    logic       M0_valid = 1'b0;
    logic [0:0] M1;
    logic       M1_valid;

    int compared = 0;
    int mismatched = 0;
    int doneCount = 0;
    int hsCount = 0;

    logic [255:0] parityImg;
    logic [255:0] lowImg;
    logic [255:0] onesImg;

    lut_neuron_table_loader #(
        .IN_BITS  (8),
        .OUT_BITS (1),
        .CFG_W    (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_start    (cfg_start),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_data     (cfg_data),
        .cfg_busy     (cfg_busy),
        .cfg_done     (cfg_done),
        .table_loaded (table_loaded),
        .M0           (M0),
        .M0_valid     (M0_valid),
        .M1           (M1),
        .M1_valid     (M1_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cfg_done === 1'b1) doneCount++;
        if (cfg_valid === 1'b1 && cfg_ready === 1'b1) hsCount++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one beat, optionally after idle gaps, and wait (bounded) for its handshake.
    task automatic applyStimulus(input logic [7:0] data, input bit gaps);
        bit accepted;
        int waitCycles;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                cfg_valid = 1'b0;
                tick();
            end
        end
        cfg_valid  = 1'b1;
        cfg_data   = data;
        accepted   = 1'b0;
        waitCycles = 0;
        while (!accepted && waitCycles < 50) begin
            accepted = cfg_ready;
            tick();
            waitCycles++;
        end
        cfg_valid = 1'b0;
        checkOutput("beat_accepted", 32'(accepted), 32'd1);
    endtask

    task automatic startLoad();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic loadImage(input logic [255:0] img, input bit gaps);
        startLoad();
        for (int b = 0; b < 32; b++) begin
            applyStimulus(img[b*8 +: 8], gaps);
        end
    endtask

    task automatic lookup(input string tag, input logic [7:0] addr, input logic expBit);
        M0       = addr;
        M0_valid = 1'b1;
        tick();
        checkOutput({tag, "_valid"}, 32'(M1_valid), 32'd1);
        checkOutput(tag, 32'(M1), 32'(expBit));
    endtask

    initial begin
        int d0;
        int h0;
        logic [7:0] iv;

        for (int i = 0; i < 256; i++) begin
            iv           = i[7:0];
            parityImg[i] = ^iv;
            lowImg[i]    = (i < 64);
            onesImg[i]   = 1'b1;
        end

        // Reset values
        rst_n = 1'b0;
        tick();
        tick();
        checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        checkOutput("rst_cfg_busy", 32'(cfg_busy), 32'd0);
        checkOutput("rst_cfg_done", 32'(cfg_done), 32'd0);
        checkOutput("rst_table_loaded", 32'(table_loaded), 32'd0);
        checkOutput("rst_M1", 32'(M1), 32'd0);
        checkOutput("rst_M1_valid", 32'(M1_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        // Lookup before any load
        M0       = 8'h00;
        M0_valid = 1'b1;
        tick();
        checkOutput("preload_M1_valid", 32'(M1_valid), 32'd0);
        checkOutput("preload_table_loaded", 32'(table_loaded), 32'd0);
        checkOutput("preload_M1", 32'(M1), 32'd0);
        M0_valid = 1'b0;
        tick();

        // Parity table, valid held high
        d0 = doneCount;
        loadImage(parityImg, 1'b0);
        checkOutput("par_done_pulse", 32'(cfg_done), 32'd1);
        checkOutput("par_ready_in_done", 32'(cfg_ready), 32'd0);
        checkOutput("par_loaded_in_done", 32'(table_loaded), 32'd0);
        tick();
        checkOutput("par_done_low", 32'(cfg_done), 32'd0);
        checkOutput("par_done_count", 32'(doneCount - d0), 32'd1);
        checkOutput("par_loaded", 32'(table_loaded), 32'd1);
        checkOutput("par_busy", 32'(cfg_busy), 32'd0);
        lookup("par_03", 8'h03, 1'b0);
        lookup("par_07", 8'h07, 1'b1);
        lookup("par_FF", 8'hFF, 1'b0);
        M0_valid = 1'b0;
        tick();
        checkOutput("par_idle_M1_valid", 32'(M1_valid), 32'd0);
        checkOutput("par_hold_M1", 32'(M1), 32'd0);

        // Backpressure and gaps
        h0 = hsCount;
        loadImage(lowImg, 1'b1);
        tick();
        checkOutput("bp_handshakes", 32'(hsCount - h0), 32'd32);
        checkOutput("bp_loaded", 32'(table_loaded), 32'd1);
        lookup("bp_3F", 8'h3F, 1'b1);
        lookup("bp_40", 8'h40, 1'b0);
        M0_valid = 1'b0;
        tick();

        // Restart after beat 10, with a beat offered alongside the restart
        d0 = doneCount;
        startLoad();
        for (int b = 0; b <= 10; b++) applyStimulus(8'h00, 1'b0);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 8'h00;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        checkOutput("rs_busy", 32'(cfg_busy), 32'd1);
        checkOutput("rs_loaded", 32'(table_loaded), 32'd0);
        checkOutput("rs_done", 32'(cfg_done), 32'd0);
        for (int b = 0; b < 32; b++) applyStimulus(onesImg[b*8 +: 8], 1'b0);
        checkOutput("rs_done_pulse", 32'(cfg_done), 32'd1);
        tick();
        checkOutput("rs_done_count", 32'(doneCount - d0), 32'd1);
        checkOutput("rs_loaded_end", 32'(table_loaded), 32'd1);
        for (int i = 0; i < 256; i++) begin
            lookup($sformatf("rs_%02h", i), 8'(i), 1'b1);
        end
        M0_valid = 1'b0;
        tick();

        // Reset mid-load
        startLoad();
        for (int b = 0; b <= 5; b++) applyStimulus(8'hA5, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("rm_loaded", 32'(table_loaded), 32'd0);
        checkOutput("rm_busy", 32'(cfg_busy), 32'd0);
        checkOutput("rm_ready", 32'(cfg_ready), 32'd0);
        M0       = 8'hFF;
        M0_valid = 1'b1;
        tick();
        checkOutput("rm_M1_valid", 32'(M1_valid), 32'd0);
        M0_valid = 1'b0;
        tick();

        // Lookups blocked during a reload
        loadImage(onesImg, 1'b0);
        tick();
        tick();
        lookup("rl_before", 8'h03, 1'b1);
        M0_valid = 1'b0;
        startLoad();
        M0       = 8'h03;
        M0_valid = 1'b1;
        for (int b = 0; b < 32; b++) begin
            applyStimulus(parityImg[b*8 +: 8], 1'b0);
            checkOutput("rl_blocked", 32'(M1_valid), 32'd0);
        end
        checkOutput("rl_done_pulse", 32'(cfg_done), 32'd1);
        tick();
        checkOutput("rl_after_done_valid", 32'(M1_valid), 32'd0);
        checkOutput("rl_loaded", 32'(table_loaded), 32'd1);
        tick();
        checkOutput("rl_resume_valid", 32'(M1_valid), 32'd1);
        checkOutput("rl_resume_M1", 32'(M1), 32'd0);
        M0_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
